// File: rtl/operational_pkg.sv
// Shared definitions for the microprogrammed datapath:
// ALU encodings, control-word layout and a field decoder.
package operational_pkg;

   localparam int CW_WIDTH = 17;

   localparam int ALU_OP_HI = 16;
   localparam int ALU_OP_LO = 14;
   localparam int SRC_A_HI  = 13;
   localparam int SRC_A_LO  = 12;
   localparam int SRC_B_HI  = 11;
   localparam int SRC_B_LO  = 10;
   localparam int B_IMM_BIT = 9;
   localparam int DST_HI    = 8;
   localparam int DST_LO    = 7;
   localparam int WE_BIT    = 6;
   localparam int FE_BIT    = 5;
   localparam int LOAD_BIT  = 4;
   localparam int STORE_BIT = 3;
   localparam int IMM_HI    = 2;
   localparam int IMM_LO    = 0;

   typedef enum logic [2:0] {
      ALU_PASS = 3'b000,
      ALU_ADD  = 3'b001,
      ALU_SUB  = 3'b010,
      ALU_AND  = 3'b011,
      ALU_OR   = 3'b100,
      ALU_XOR  = 3'b101,
      ALU_SHL  = 3'b110,
      ALU_SHR  = 3'b111
   } alu_op_t;

   typedef struct packed {
      alu_op_t    alu_op;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       b_imm;
      logic [1:0] dst;
      logic       write_en;
      logic       flags_en;
      logic       load_input;
      logic       store_output;
      logic [2:0] imm;
   } ctrl_t;

   function automatic ctrl_t decode_cw(input logic [CW_WIDTH-1:0] cw);
      ctrl_t c;
      c.alu_op       = alu_op_t'(cw[ALU_OP_HI:ALU_OP_LO]);
      c.src_a        = cw[SRC_A_HI:SRC_A_LO];
      c.src_b        = cw[SRC_B_HI:SRC_B_LO];
      c.b_imm        = cw[B_IMM_BIT];
      c.dst          = cw[DST_HI:DST_LO];
      c.write_en     = cw[WE_BIT];
      c.flags_en     = cw[FE_BIT];
      c.load_input   = cw[LOAD_BIT];
      c.store_output = cw[STORE_BIT];
      c.imm          = cw[IMM_HI:IMM_LO];
      return c;
   endfunction

endpackage

// File: rtl/operational_unit_alu.sv
// Combinational ALU: result, carry/borrow and zero
// for the eight datapath operations.
module alu
   import operational_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_t          op,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH:0] wide;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      wide   = '0;
      unique case (op)
         ALU_PASS: result = b;
         ALU_ADD: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[WIDTH-1:0];
            carry  = wide[WIDTH];
         end
         ALU_SUB: begin
            // borrow appears as the extra top bit of the wide difference
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[WIDTH-1:0];
            carry  = wide[WIDTH];
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SHL: begin
            result = {a[WIDTH-2:0], 1'b0};
            carry  = a[WIDTH-1];
         end
         ALU_SHR: begin
            result = {1'b0, a[WIDTH-1:1]};
            carry  = a[0];
         end
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/operational_unit.sv
// Datapath stage: register file, ALU, flags and output
// register driven by the control unit's microword.
module operational_unit
   import operational_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CW_WIDTH-1:0] control_bus,
   input  logic [WIDTH-1:0]    data_in,
   output logic [WIDTH-1:0]    data_out,
   output logic                out_valid,
   output logic                carry_flag,
   output logic                zero_flag
);

   ctrl_t            ctrl;
   logic [WIDTH-1:0] regs [4];
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] imm_ext;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_zero;
   logic             reg_we;
   logic [WIDTH-1:0] reg_wdata;

   assign ctrl    = decode_cw(control_bus);
   assign imm_ext = {{(WIDTH-3){1'b0}}, ctrl.imm};
   assign op_a    = regs[ctrl.src_a];
   assign op_b    = ctrl.b_imm ? imm_ext : regs[ctrl.src_b];

   alu #(.WIDTH(WIDTH)) u_alu (
      .a      (op_a),
      .b      (op_b),
      .op     (ctrl.alu_op),
      .result (alu_res),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   // external load takes priority over the ALU writeback
   assign reg_we    = ctrl.load_input | ctrl.write_en;
   assign reg_wdata = ctrl.load_input ? data_in : alu_res;

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (reg_we) begin
         regs[ctrl.dst] <= reg_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
      end else if (ctrl.flags_en) begin
         carry_flag <= alu_carry;
         zero_flag  <= alu_zero;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         data_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= ctrl.store_output;
         if (ctrl.store_output) data_out <= op_a;
      end
   end

endmodule

// File: tb/tb_operational_unit.sv
// Directed self-checking bench for operational_unit.
module tb_operational_unit;
   import operational_pkg::*;

   logic                clock = 1'b0;
   logic                reset = 1'b0;
   logic [CW_WIDTH-1:0] control_bus = '0;
   logic [7:0]          data_in = '0;
   logic [7:0]          data_out;
   logic                out_valid;
   logic                carry_flag;
   logic                zero_flag;

   int checks = 0;
   int errors = 0;

   operational_unit #(.WIDTH(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .control_bus (control_bus),
      .data_in     (data_in),
      .data_out    (data_out),
      .out_valid   (out_valid),
      .carry_flag  (carry_flag),
      .zero_flag   (zero_flag)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] cw(
      input alu_op_t op, input logic [1:0] sa, input logic [1:0] sb,
      input logic bimm, input logic [1:0] dst, input logic we,
      input logic fe, input logic li, input logic so, input logic [2:0] imm);
      return {op, sa, sb, bimm, dst, we, fe, li, so, imm};
   endfunction

   task automatic step(input logic [16:0] c, input logic [7:0] d);
      @(negedge clock);
      control_bus = c;
      data_in     = d;
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [1:0] r, input logic [7:0] d);
      step(cw(ALU_PASS, 0, 0, 0, r, 0, 0, 1, 0, 0), d);
   endtask

   task automatic store(input logic [1:0] r);
      step(cw(ALU_PASS, r, 0, 0, 0, 0, 0, 0, 1, 0), 8'h00);
   endtask

   initial begin
      reset = 1'b0;
      step('0, 8'h00);
      step('0, 8'h00);
      check("rst_data_out", data_out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_carry", carry_flag, 0);
      check("rst_zero", zero_flag, 0);
      reset = 1'b1;

      load(0, 8'hF0);
      load(1, 8'h20);
      step(cw(ALU_ADD, 0, 1, 0, 2, 1, 1, 0, 0, 0), 8'h00);
      check("add_carry", carry_flag, 1);
      check("add_zero", zero_flag, 0);
      store(2);
      check("add_result", data_out, 8'h10);
      check("store_valid", out_valid, 1);
      step('0, 8'h00);
      check("valid_drop", out_valid, 0);
      check("data_hold", data_out, 8'h10);

      load(0, 8'h05);
      step(cw(ALU_SUB, 0, 0, 1, 0, 0, 1, 0, 0, 5), 8'h00);
      check("sub_eq_zero", zero_flag, 1);
      check("sub_eq_carry", carry_flag, 0);
      step(cw(ALU_SUB, 0, 0, 1, 1, 1, 1, 0, 0, 7), 8'h00);
      check("sub_bor_carry", carry_flag, 1);
      check("sub_bor_zero", zero_flag, 0);
      store(1);
      check("sub_bor_result", data_out, 8'hFE);

      // read-during-write returns the old value
      step(cw(ALU_ADD, 1, 0, 1, 1, 1, 0, 0, 1, 1), 8'h00);
      check("rdw_old", data_out, 8'hFE);
      store(1);
      check("rdw_new", data_out, 8'hFF);

      load(0, 8'h81);
      step(cw(ALU_SHL, 0, 0, 0, 2, 1, 1, 0, 0, 0), 8'h00);
      check("shl_carry", carry_flag, 1);
      check("shl_zero", zero_flag, 0);
      step(cw(ALU_ADD, 3, 0, 1, 3, 1, 0, 0, 0, 0), 8'h00);
      check("hold_carry", carry_flag, 1);
      check("hold_zero", zero_flag, 0);
      store(2);
      check("shl_result", data_out, 8'h02);

      step(cw(ALU_ADD, 0, 0, 1, 3, 1, 0, 1, 0, 1), 8'h5A);
      store(3);
      check("load_wins", data_out, 8'h5A);
      check("load_valid", out_valid, 1);
      store(0);
      check("b2b_data", data_out, 8'h81);
      check("b2b_valid", out_valid, 1);
      step('0, 8'h00);
      check("b2b_drop", out_valid, 0);

      load(0, 8'h33);
      for (int i = 0; i < 3; i++) begin
         step('0, 8'hAA);
         check("nop_valid", out_valid, 0);
         check("nop_data", data_out, 8'h81);
         check("nop_carry", carry_flag, 1);
         check("nop_zero", zero_flag, 0);
      end
      store(0);
      check("nop_r0", data_out, 8'h33);
      store(3);
      check("nop_r3", data_out, 8'h5A);

      @(negedge clock);
      reset = 1'b0;
      control_bus = cw(ALU_SUB, 0, 0, 1, 0, 1, 1, 0, 1, 7);
      @(posedge clock);
      #1;
      check("mrst_data", data_out, 0);
      check("mrst_valid", out_valid, 0);
      check("mrst_carry", carry_flag, 0);
      check("mrst_zero", zero_flag, 0);
      reset = 1'b1;
      store(0);
      check("mrst_r0", data_out, 8'h00);
      check("mrst_store_valid", out_valid, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/operational_unit.md
# operational_unit

Datapath stage driven by the microprogrammed control unit. Each cycle it decodes the 17-bit control word into register-file reads, one ALU operation, an optional register write, input load and output store. It returns the registered `carry_flag` and `zero_flag` that the control unit uses for conditional branching. An all-zero control word (issued by the control unit during jump commands) is a guaranteed no-op.

## Interface
- `WIDTH`, 8, datapath width in bits (≥ 4)
- `clock`  input  1  sole clock, rising edge
- `reset`  input  1  synchronous, active-low; sampled on rising `clock`
- `control_bus`  input  17  control word from the control unit, valid for the whole cycle
- `data_in`  input  WIDTH  external operand, sampled when `load_input` = 1
- `data_out`  output  WIDTH  registered output value
- `out_valid`  output  1  one-cycle strobe, high the cycle after a store
- `carry_flag`  output  1  registered carry/borrow flag
- `zero_flag`  output  1  registered zero flag

## Operation
- Control word fields:
  - [16:14] `alu_op`
  - [13:12] `src_a`
  - [11:10] `src_b`
  - [9] `b_imm`
  - [8:7] `dst`
  - [6] `write_en`
  - [5] `flags_en`
  - [4] `load_input`
  - [3] `store_output`
  - [2:0] `imm`
- Register file: R0–R3, WIDTH bits each. Reads are combinational; writes occur on the clock edge.
- Operand A = R[`src_a`]. Operand B = `b_imm` ? zero-extended `imm` : R[`src_b`].
- `alu_op` results and carry:
  - 000 PASS_B: result B, carry 0
  - 001 ADD: result A+B, carry = carry-out
  - 010 SUB: result A−B mod 2^WIDTH, carry = borrow (A < B, unsigned)
  - 011 AND, 100 OR, 101 XOR: carry 0
  - 110 SHL: A<<1, carry = A[WIDTH-1]
  - 111 SHR (logical): A>>1, carry = A[0]
- Zero = (result == 0).
- `write_en`: R[`dst`] ← ALU result.
- `load_input`: R[`dst`] ← `data_in`. If both `load_input` and `write_en` are set, `load_input` wins.
- `flags_en`: `carry_flag`/`zero_flag` ← ALU carry/zero. When `flags_en` = 0, both flags hold, including during load cycles.
- `store_output`: `data_out` ← operand A; `out_valid` = 1 for exactly the next cycle. `data_out` holds between stores.
- Control word 0 (PASS_B, no enables): no state change, and `out_valid` deasserts.
- Reset (`reset` = 0 at an edge): R0–R3 = 0, `carry_flag` = 0, `zero_flag` = 0, `data_out` = 0, `out_valid` = 0. Reset overrides every field of the same-cycle control word, including mid-sequence.

## Timing
- Single-cycle execute. The control word in cycle n takes effect at the edge ending cycle n.
- Flags written by the command at PC n are visible to the branch command at PC n+1.
- Read-during-write to the same register returns the old value; there is no bypass.
- No back-pressure and no stall: consumer of `data_out` must accept every `out_valid` pulse.
- Back-to-back stores produce a continuous `out_valid` with a new `data_out` each cycle.
- Flag outputs come straight from flops; no combinational path from `control_bus` to any output.

## Structure
- Shared package `operational_pkg`:
  - `alu_op` encodings (ALU_PASS … ALU_SHR)
  - control-word field bit positions
  - control word width constant (17) for reuse by the control unit's microcode tooling
- One natural sub-module: `alu`, purely combinational (A, B, op → result, carry, zero), parameterised by WIDTH.
- Register file, flags and output register stay in the top module.

## Test plan
- Reset, then load 0xF0 → R0 and 0x20 → R1; ADD R0,R1 → R2 with `flags_en` → R2 = 0x10, `carry_flag` = 1, `zero_flag` = 0.
- R0 = 0x05, SUB R0, imm 5 with `flags_en` → result 0x00, `zero_flag` = 1, `carry_flag` = 0. Then SUB R0, imm 7 → 0xFE, `carry_flag` = 1, `zero_flag` = 0.
- SHL of 0x81 → 0x02, carry 1. A following cycle with `flags_en` = 0 and an ADD producing 0 → flags unchanged (1, 0).
- Same cycle `load_input` = 1, `write_en` = 1, `dst` = R3, `data_in` = 0x5A → R3 = 0x5A. Store R3 → `data_out` = 0x5A, `out_valid` high exactly one cycle.
- All-zero control word for 3 cycles after loading R0 = 0x33 → registers, flags and `data_out` unchanged; `out_valid` = 0.
- Assert `reset` = 0 for one edge during a store-plus-flag-update sequence → all outputs 0 next cycle, and R0 read back via store = 0x00.
